// File: rtl/hitchhike_pkg.sv
// Shared state encoding, default timing constants and helpers for the
// tag transmit path.
package hitchhike_pkg;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ARMED    = 3'd1;
   localparam logic [2:0] S_PREAMBLE = 3'd2;
   localparam logic [2:0] S_PAYLOAD  = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = S_IDLE,
      ARMED    = S_ARMED,
      PREAMBLE = S_PREAMBLE,
      PAYLOAD  = S_PAYLOAD,
      DONE     = S_DONE
   } state_t;

   localparam int SYM_CYCLES_DEF    = 10;
   localparam int PREAMBLE_SYMS_DEF = 192;
   localparam int DATA_W_DEF        = 32;
   localparam int SHIFT_HALF_DEF    = 1;

   // Counter width that never collapses to zero bits.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer for an asynchronous trigger plus a history flop
// producing a one-cycle rising-edge pulse.
module trig_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic sync1_r;
   logic sync2_r;
   logic sync3_r;

   // Synchronizer chain followed by the edge-history stage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= async_in;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   assign rise = sync2_r & ~sync3_r;

endmodule

// File: rtl/tag_bit_modulator.sv
// Backscatter tag modulator: latches a payload, waits for a packet-detect
// edge, then drives a phase-inverted square wave onto the RF switch.
module tag_bit_modulator
   import hitchhike_pkg::*;
#(
   parameter int SYM_CYCLES    = SYM_CYCLES_DEF,
   parameter int PREAMBLE_SYMS = PREAMBLE_SYMS_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int SHIFT_HALF    = SHIFT_HALF_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              trigger_signal,
   output logic              signal_into_switch,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int SW = cnt_width(SYM_CYCLES);
   localparam int PW = cnt_width(PREAMBLE_SYMS + 1);
   localparam int BW = cnt_width(DATA_W + 1);
   localparam int HW = cnt_width(SHIFT_HALF + 1);

   localparam logic [SW-1:0] SYM_LAST  = SW'(SYM_CYCLES - 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_SYMS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(SHIFT_HALF - 1);

   state_t            state_r;
   logic [SW-1:0]     sym_cnt_r;
   logic [PW-1:0]     pre_cnt_r;
   logic [BW-1:0]     bit_cnt_r;
   logic [HW-1:0]     half_cnt_r;
   logic [DATA_W-1:0] shreg_r;
   logic              wave_r;
   logic              switch_r;
   logic              busy_r;
   logic              done_r;
   logic              ready_r;

   logic              trig_rise_s;
   logic              sym_end_s;
   logic              half_end_s;
   logic              wave_nx_s;

   trig_edge_sync u_trig_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (trigger_signal),
      .rise     (trig_rise_s)
   );

   assign sym_end_s  = (sym_cnt_r == SYM_LAST);
   assign half_end_s = (half_cnt_r == HALF_LAST);
   assign wave_nx_s  = wave_r ^ half_end_s;

   // Transmit FSM with counters, shift register, wave divider and output registers.
   // The switch register is loaded from next-cycle wave/bit values so it lines up with state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         sym_cnt_r  <= '0;
         pre_cnt_r  <= '0;
         bit_cnt_r  <= '0;
         half_cnt_r <= '0;
         shreg_r    <= '0;
         wave_r     <= 1'b0;
         switch_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ready_r    <= 1'b1;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               switch_r <= 1'b0;
               busy_r   <= 1'b0;
               if (data_valid && ready_r) begin
                  shreg_r <= data_in;
                  ready_r <= 1'b0;
                  state_r <= ARMED;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ARMED: begin
               if (trig_rise_s) begin
                  state_r    <= PREAMBLE;
                  sym_cnt_r  <= '0;
                  pre_cnt_r  <= '0;
                  half_cnt_r <= '0;
                  wave_r     <= 1'b0;
                  switch_r   <= 1'b0;
                  busy_r     <= 1'b1;
               end else begin
                  state_r <= ARMED;
               end
            end
            PREAMBLE: begin
               wave_r     <= wave_nx_s;
               half_cnt_r <= half_end_s ? '0 : half_cnt_r + HW'(1);
               if (sym_end_s) begin
                  sym_cnt_r <= '0;
                  if (pre_cnt_r == PRE_LAST) begin
                     state_r   <= PAYLOAD;
                     pre_cnt_r <= '0;
                     bit_cnt_r <= '0;
                     switch_r  <= wave_nx_s ^ shreg_r[DATA_W-1];
                  end else begin
                     pre_cnt_r <= pre_cnt_r + PW'(1);
                     switch_r  <= wave_nx_s;
                  end
               end else begin
                  sym_cnt_r <= sym_cnt_r + SW'(1);
                  switch_r  <= wave_nx_s;
               end
            end
            PAYLOAD: begin
               wave_r     <= wave_nx_s;
               half_cnt_r <= half_end_s ? '0 : half_cnt_r + HW'(1);
               if (sym_end_s) begin
                  sym_cnt_r <= '0;
                  shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
                  if (bit_cnt_r == BIT_LAST) begin
                     state_r   <= DONE;
                     bit_cnt_r <= '0;
                     switch_r  <= 1'b0;
                     busy_r    <= 1'b0;
                     done_r    <= 1'b1;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BW'(1);
                     switch_r  <= wave_nx_s ^ shreg_r[DATA_W-2];
                  end
               end else begin
                  sym_cnt_r <= sym_cnt_r + SW'(1);
                  switch_r  <= wave_nx_s ^ shreg_r[DATA_W-1];
               end
            end
            DONE: begin
               state_r  <= IDLE;
               ready_r  <= 1'b1;
               switch_r <= 1'b0;
               busy_r   <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               ready_r  <= 1'b1;
               switch_r <= 1'b0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign signal_into_switch = switch_r;
   assign tx_busy            = busy_r;
   assign tx_done            = done_r;
   assign data_ready         = ready_r;

endmodule

// File: tb/tb_tag_bit_modulator.sv
// Randomized self-checking bench for tag_bit_modulator against a per-cycle
// waveform model derived from the packet timing rules.
module tb_tag_bit_modulator;

   localparam int SYM     = 10;
   localparam int PRE     = 4;
   localparam int DW      = 8;
   localparam int HALF    = 1;
   localparam int PRE_CLK = PRE * SYM;
   localparam int PAY_CLK = DW * SYM;
   localparam int END_I   = PRE_CLK + PAY_CLK;

   logic          clock;
   logic          reset;
   logic [DW-1:0] data_in;
   logic          data_valid;
   logic          data_ready;
   logic          trigger_signal;
   logic          signal_into_switch;
   logic          tx_busy;
   logic          tx_done;

   int n_checks = 0;
   int n_errors = 0;

   tag_bit_modulator #(
      .SYM_CYCLES    (SYM),
      .PREAMBLE_SYMS (PRE),
      .DATA_W        (DW),
      .SHIFT_HALF    (HALF)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .data_in            (data_in),
      .data_valid         (data_valid),
      .data_ready         (data_ready),
      .trigger_signal     (trigger_signal),
      .signal_into_switch (signal_into_switch),
      .tx_busy            (tx_busy),
      .tx_done            (tx_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Switch level i clocks after PREAMBLE entry for payload w.
   function automatic logic exp_sw(input logic [DW-1:0] w, input int i);
      int wave;
      int b;
      wave = (i / HALF) % 2;
      b    = 0;
      if (i < PRE_CLK) return wave[0];
      if (i < END_I) begin
         b = (i - PRE_CLK) / SYM;
         return wave[0] ^ w[DW-1-b];
      end
      return 1'b0;
   endfunction

   // Expected {tx_busy, tx_done, data_ready} i clocks after PREAMBLE entry.
   function automatic logic [2:0] exp_status(input int i);
      if (i < END_I) return 3'b100;
      if (i == END_I) return 3'b010;
      return 3'b001;
   endfunction

   task automatic send_word(input logic [DW-1:0] w);
      @(posedge clock); #1;
      data_in    = w;
      data_valid = 1'b1;
      @(posedge clock); #1;
      data_valid = 1'b0;
      @(negedge clock);
      check_eq("accept_ready", {31'd0, data_ready}, 32'd0);
   endtask

   task automatic fire_and_check(input logic [DW-1:0] w, input int off, input bit mid_pulse,
                                 input int stop_at);
      int edges;
      edges = 0;
      @(posedge clock); #(off);
      trigger_signal = 1'b1;
      while (edges < 10) begin
         @(posedge clock);
         edges++;
         @(negedge clock);
         if (tx_busy) break;
      end
      check_eq("trig_latency", edges, 32'd3);
      if (edges >= 10) begin
         trigger_signal = 1'b0;
         return;
      end
      for (int i = 0; i <= END_I + 1; i++) begin
         if (i > 0) @(negedge clock);
         check_eq($sformatf("sw_%0d", i), {31'd0, signal_into_switch}, {31'd0, exp_sw(w, i)});
         check_eq($sformatf("status_%0d", i), {29'd0, tx_busy, tx_done, data_ready},
                  {29'd0, exp_status(i)});
         if (i == 2) trigger_signal = 1'b0;
         if (mid_pulse && i == 60) trigger_signal = 1'b1;
         if (mid_pulse && i == 63) trigger_signal = 1'b0;
         if (i == stop_at) return;
      end
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clock);
         if (tx_busy || tx_done || signal_into_switch) seen++;
      end
      check_eq(tag, seen, 32'd0);
   endtask

   initial begin
      logic [DW-1:0] w;
      int            off;
      reset          = 1'b0;
      data_in        = '0;
      data_valid     = 1'b0;
      trigger_signal = 1'b0;

      #12;
      check_eq("reset_outs", {28'd0, signal_into_switch, tx_busy, tx_done, data_ready}, 32'h1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("post_reset_ready", {31'd0, data_ready}, 32'd1);

      // Trigger with no payload loaded: nothing happens
      @(posedge clock); #3;
      trigger_signal = 1'b1;
      repeat (4) @(negedge clock);
      trigger_signal = 1'b0;
      watch_quiet("idle_trigger", 8);
      check_eq("idle_ready", {31'd0, data_ready}, 32'd1);

      send_word(8'hA5);
      fire_and_check(8'hA5, 1, 1'b1, 1000);
      watch_quiet("after_a5", 6);

      send_word(8'h00);
      fire_and_check(8'h00, 7, 1'b0, 1000);

      // Trigger already high before arming must not start transmission
      @(posedge clock); #2;
      trigger_signal = 1'b1;
      repeat (6) @(negedge clock);
      send_word(8'h3C);
      watch_quiet("held_trigger", 10);
      trigger_signal = 1'b0;
      repeat (4) @(negedge clock);
      fire_and_check(8'h3C, 3, 1'b0, 1000);

      // Payload offered during a transmission waits for IDLE
      send_word(8'h0F);
      data_in    = 8'hFF;
      data_valid = 1'b1;
      fire_and_check(8'h0F, 6, 1'b0, 1000);
      @(posedge clock); #1;
      data_valid = 1'b0;
      @(negedge clock);
      check_eq("ff_accept", {31'd0, data_ready}, 32'd0);
      fire_and_check(8'hFF, 2, 1'b0, 1000);

      // Reset in the middle of bit 3
      send_word(8'hC3);
      fire_and_check(8'hC3, 4, 1'b0, PRE_CLK + 3 * SYM + 5);
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_reset", {28'd0, signal_into_switch, tx_busy, tx_done, data_ready}, 32'h1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("reset_idle_ready", {31'd0, data_ready}, 32'd1);
      @(posedge clock); #5;
      trigger_signal = 1'b1;
      repeat (4) @(negedge clock);
      trigger_signal = 1'b0;
      watch_quiet("stale_payload", 20);

      // Random payloads with off-grid trigger timing
      for (int k = 0; k < 5; k++) begin
         w   = DW'($urandom);
         off = int'($urandom_range(1, 9));
         send_word(w);
         fire_and_check(w, off, k[0], 1000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
